// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
//   Drives an MCP3008-class 8-channel 10-bit SPI ADC to convert a set of
//   channels in ascending index order. Each conversion result is stored in an
//   8x10 result file and is also emitted as a one-cycle result stream.
//   The scan can run once or repeat automatically.
//
// Ports
//   clk           system clock; all logic runs on its rising edge
//   rst_n         synchronous reset, active-low
//   ch_enable     channel mask; bit i set means channel i is scanned
//   single_ended  1 = single-ended conversion, 0 = pseudo-differential
//   scan_start    one-cycle pulse that starts a scan from idle
//   continuous    1 = start a new scan automatically after each one ends
//   busy          high from an accepted start until the scan is complete
//   sclk/cs_n     ADC serial clock (idles low) and chip select (active-low)
//   mosi/miso     ADC DIN / DOUT
//   result_valid  one-cycle pulse; result_ch/result_data carry a new result
//   result_ch     channel of the current result
//   result_data   conversion value, bit 9 = MSB
//   scan_done     one-cycle pulse that comes with the last result of a scan
//   rd_ch/rd_data combinational read port of the result file
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
  parameter int CLK_DIV = 27,  // clk cycles per sclk half-period
  parameter int CSH_CYC = 27,  // clk cycles cs_n stays high between frames
  parameter int GAP_CYC = 0    // idle cycles before a continuous re-arm
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ch_enable,
  input  logic       single_ended,
  input  logic       scan_start,
  input  logic       continuous,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso,
  output logic       result_valid,
  output logic [2:0] result_ch,
  output logic [9:0] result_data,
  output logic       scan_done,
  input  logic [2:0] rd_ch,
  output logic [9:0] rd_data
);

  localparam int CW = 16;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CSH_LAST = CW'(CSH_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_CSHOLD, S_GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;       // cycle counter within the current phase
  logic [4:0]    bit_idx;   // sclk rising edge number in the frame, 1..17
  logic [7:0]    pend;      // channels of this scan not yet converted
  logic [2:0]    cur_ch;
  logic          sgl;
  logic [9:0]    shreg;
  logic [9:0]    rfile [8];
  logic [7:0]    pend_clr;

  // Lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_ch = 3'(i);
    end
  endfunction

  // DIN bit presented before sclk rising edge n: start, SGL/DIFF, D2..D0.
  function automatic logic cmd_bit(input logic [4:0] n, input logic s,
                                   input logic [2:0] ch);
    case (n)
      5'd1:    cmd_bit = 1'b1;
      5'd2:    cmd_bit = s;
      5'd3:    cmd_bit = ch[2];
      5'd4:    cmd_bit = ch[1];
      5'd5:    cmd_bit = ch[0];
      default: cmd_bit = 1'b0;
    endcase
  endfunction

  assign pend_clr = pend & ~(8'b1 << cur_ch);
  assign rd_data  = rfile[rd_ch];

  // NOTE: every register in this block, including the result file, is
  // assigned with <= so all reads within a cycle see pre-edge values; the file
  // is cleared by reset because its all-zero contents are observable state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      pend         <= '0;
      cur_ch       <= '0;
      sgl          <= 1'b0;
      shreg        <= '0;
      busy         <= 1'b0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      scan_done    <= 1'b0;
      for (int i = 0; i < 8; i++) rfile[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      scan_done    <= 1'b0;
      // The file is written at the end of the result_valid cycle, so a read
      // in that same cycle still returns the previous entry.
      if (result_valid) rfile[result_ch] <= result_data;

      case (state)
        S_IDLE: begin
          if (scan_start && ch_enable != 8'd0) begin
            pend   <= ch_enable;
            sgl    <= single_ended;
            cur_ch <= lowest_ch(ch_enable);
            busy   <= 1'b1;
            cs_n   <= 1'b0;
            mosi   <= 1'b1;
            cnt    <= '0;
            state  <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            sclk    <= 1'b1;
            bit_idx <= 5'd1;
            state   <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (sclk) begin
              // End of a high half: sample DOUT, then fall and present the
              // bit for the next rising edge.
              sclk <= 1'b0;
              if (bit_idx >= 5'd8) shreg <= {shreg[8:0], miso};
              mosi <= cmd_bit(5'(bit_idx + 5'd1), sgl, cur_ch);
            end else if (bit_idx == 5'd17) begin
              cs_n         <= 1'b1;
              mosi         <= 1'b0;
              result_valid <= 1'b1;
              result_ch    <= cur_ch;
              result_data  <= shreg;
              pend         <= pend_clr;
              scan_done    <= (pend_clr == 8'd0);
              state        <= S_CSHOLD;
            end else begin
              sclk    <= 1'b1;
              bit_idx <= 5'(bit_idx + 5'd1);
            end
          end
        end

        S_CSHOLD: begin
          if (cnt != CSH_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (pend != 8'd0) begin
              cur_ch <= lowest_ch(pend);
              cs_n   <= 1'b0;
              mosi   <= 1'b1;
              state  <= S_SETUP;
            end else if (!continuous) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (GAP_CYC > 0) begin
              state <= S_GAP;
            end else if (ch_enable != 8'd0) begin
              pend   <= ch_enable;
              sgl    <= single_ended;
              cur_ch <= lowest_ch(ch_enable);
              cs_n   <= 1'b0;
              mosi   <= 1'b1;
              state  <= S_SETUP;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        S_GAP: begin
          if (cnt != GAP_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (ch_enable != 8'd0) begin
              pend   <= ch_enable;
              sgl    <= single_ended;
              cur_ch <= lowest_ch(ch_enable);
              cs_n   <= 1'b0;
              mosi   <= 1'b1;
              state  <= S_SETUP;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
